// File: rtl/matrix_scan_ctrl_if.sv
// matrix_scan_ctrl_if: framebuffer write/swap bus and LED matrix drive for the scan controller
interface matrix_scan_ctrl_if;
  logic        ENABLE;
  logic        WR_EN;
  logic [2:0]  WR_ROW;
  logic [15:0] WR_DATA;
  logic        SWAP_REQ;
  logic        SWAP_DONE;
  logic        FRAME_START;
  logic [7:0]  MATRIX_ROW;
  logic [15:0] MATRIX_COL;
  modport master (
    output ENABLE, WR_EN, WR_ROW, WR_DATA, SWAP_REQ,
    input  SWAP_DONE, FRAME_START, MATRIX_ROW, MATRIX_COL
  );
  modport slave (
    input  ENABLE, WR_EN, WR_ROW, WR_DATA, SWAP_REQ,
    output SWAP_DONE, FRAME_START, MATRIX_ROW, MATRIX_COL
  );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: double-buffered 8x16 LED matrix row scanner with blanking and tear-free swap
module matrix_scan_ctrl #(
  parameter int PRESCALE = 2500,
  parameter int BLANK    = 64
) (
  input logic              MCLK,
  input logic              RST_N,
  matrix_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(PRESCALE);
  logic [CW-1:0] cnt;
  logic [2:0]    row;
  logic          front, pending;
  logic [15:0]   fb [2][8];
  logic          last, boundary, swap, off;
  always_comb begin
    last     = cnt == CW'(PRESCALE - 1);
    boundary = last && row == 3'd7;
    swap     = (pending || bus.SWAP_REQ) && (boundary || !bus.ENABLE);
    off      = !bus.ENABLE || cnt < CW'(BLANK);
  end
  always_ff @(posedge MCLK)
    if (!RST_N) begin
      cnt             <= '0;
      row             <= '0;
      front           <= 1'b0;
      pending         <= 1'b0;
      bus.SWAP_DONE   <= 1'b0;
      bus.FRAME_START <= 1'b0;
      bus.MATRIX_ROW  <= 8'hFF;
      bus.MATRIX_COL  <= 16'hFFFF;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 8; r++)
          fb[b][r] <= '0;
    end else begin
      cnt             <= (!bus.ENABLE || last) ? '0 : cnt + 1'b1;
      row             <= !bus.ENABLE ? 3'd0 : row + 3'(last);
      front           <= front ^ swap;
      pending         <= !swap && (pending || bus.SWAP_REQ);
      bus.SWAP_DONE   <= swap;
      bus.FRAME_START <= bus.ENABLE && boundary;
      bus.MATRIX_ROW  <= off ? 8'hFF : ~(8'b1 << row);
      bus.MATRIX_COL  <= off ? 16'hFFFF : ~fb[front][row];
      // the writer only ever touches the hidden buffer, so the displayed row cannot change mid-slot
      if (bus.WR_EN) fb[~front][bus.WR_ROW] <= bus.WR_DATA;
    end
endmodule
